// File: rtl/odu_gen_data.sv
// ODU test-traffic generator: word-interleaved 384-bit frame/row data over a channel range,
// configured through a 16-bit chip-select register bus.
module odu_gen_data #(
    parameter logic [15:0] ID_VAL = 16'h0D01
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cfg_n_cs,
    input  logic         cfg_n_we,
    input  logic         cfg_n_oe,
    input  logic [3:0]   cfg_addr,
    input  logic [15:0]  cfg_din,
    output logic [15:0]  cfg_dout,
    output logic [6:0]   chid_out,
    output logic [386:0] data_out
);

    logic [15:0] chan_q, size_q, patt_q, ctrl_q, stat_q;
    logic        sh_tag_q, sh_inc_q;
    logic [6:0]  sh_ch_lo_q, sh_ch_hi_q;
    logic [15:0] sh_size_q;
    logic [7:0]  sh_seed_q;
    logic        active_q;
    logic [6:0]  ch_q;
    logic [7:0]  wrd_q, row_q;

    logic        wr_en, run, start;
    logic [15:0] rd_val;
    logic        tag_en, inc_mode;
    logic [6:0]  ch_lo, ch_hi, ch_cur, ch_d;
    logic [7:0]  rows_m1, words_m1, seed, wrd_cur, row_cur, wrd_d, row_d, pos;
    logic        ch_wrap, wrd_wrap, row_wrap, frame_wrap, fs, rs;
    logic [383:0] word_d;
    logic [15:0] stat_d;

    assign wr_en = ~cfg_n_cs & ~cfg_n_we;
    assign run   = ctrl_q[0];
    assign start = run & ~active_q;

    // Register file writes; ID and STAT are read-only.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            chan_q <= '0;
            size_q <= '0;
            patt_q <= '0;
            ctrl_q <= '0;
        end else if (wr_en) begin
            case (cfg_addr)
                4'd1:    chan_q <= cfg_din;
                4'd3:    size_q <= cfg_din;
                4'd6:    patt_q <= cfg_din;
                4'd11:   ctrl_q <= cfg_din;
                default: ;
            endcase
        end
    end

    // Combinational read mux, gated by chip select and output enable.
    always_comb begin
        rd_val = '0;
        case (cfg_addr)
            4'd0:    rd_val = ID_VAL;
            4'd1:    rd_val = chan_q;
            4'd3:    rd_val = size_q;
            4'd6:    rd_val = patt_q;
            4'd11:   rd_val = ctrl_q;
            4'd12:   rd_val = stat_q;
            default: rd_val = '0;
        endcase
        cfg_dout = (!cfg_n_cs && !cfg_n_oe) ? rd_val : 16'h0000;
    end

    // Current word: the start cycle uses live registers because shadows load on that same edge.
    always_comb begin
        tag_en   = start ? chan_q[15]    : sh_tag_q;
        ch_lo    = start ? chan_q[14:8]  : sh_ch_lo_q;
        ch_hi    = start ? chan_q[6:0]   : sh_ch_hi_q;
        rows_m1  = start ? size_q[15:8]  : sh_size_q[15:8];
        words_m1 = start ? size_q[7:0]   : sh_size_q[7:0];
        inc_mode = start ? patt_q[15]    : sh_inc_q;
        seed     = start ? patt_q[7:0]   : sh_seed_q;

        ch_cur  = start ? ch_lo : ch_q;
        wrd_cur = start ? 8'd0  : wrd_q;
        row_cur = start ? 8'd0  : row_q;

        // ch >= ch_hi also covers an inverted range, which collapses to ch_lo alone.
        ch_wrap    = (ch_cur >= ch_hi);
        wrd_wrap   = (wrd_cur == words_m1);
        row_wrap   = (row_cur == rows_m1);
        frame_wrap = ch_wrap & wrd_wrap & row_wrap;

        fs  = (row_cur == 8'd0) && (wrd_cur == 8'd0);
        rs  = (wrd_cur == 8'd0);
        pos = row_cur * (words_m1 + 8'd1) + wrd_cur;

        word_d = '0;
        for (int k = 0; k < 48; k++) begin
            word_d[8*k +: 8] = inc_mode ? (seed + pos + 8'(k)) : seed;
        end
        if (tag_en) word_d[383:376] = {1'b0, ch_cur};

        ch_d  = ch_cur + 7'd1;
        wrd_d = wrd_cur;
        row_d = row_cur;
        if (ch_wrap) begin
            // At frame wrap the next frame starts from the freshly shadowed ch_lo.
            ch_d  = frame_wrap ? chan_q[14:8] : ch_lo;
            wrd_d = wrd_wrap ? 8'd0 : wrd_cur + 8'd1;
            if (wrd_wrap) row_d = row_wrap ? 8'd0 : row_cur + 8'd1;
        end

        stat_d = (start ? 16'd0 : stat_q) + {15'd0, frame_wrap};
    end

    // Generator state, shadow registers, frame counter and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            active_q   <= 1'b0;
            ch_q       <= '0;
            wrd_q      <= '0;
            row_q      <= '0;
            stat_q     <= '0;
            sh_tag_q   <= 1'b0;
            sh_ch_lo_q <= '0;
            sh_ch_hi_q <= '0;
            sh_size_q  <= '0;
            sh_inc_q   <= 1'b0;
            sh_seed_q  <= '0;
            data_out   <= '0;
            chid_out   <= '0;
        end else if (!run) begin
            active_q <= 1'b0;
            ch_q     <= '0;
            wrd_q    <= '0;
            row_q    <= '0;
            data_out <= '0;
            chid_out <= '0;
        end else begin
            active_q <= 1'b1;
            ch_q     <= ch_d;
            wrd_q    <= wrd_d;
            row_q    <= row_d;
            stat_q   <= stat_d;
            data_out <= {1'b1, fs, rs, word_d};
            chid_out <= ch_cur;
            if (start || frame_wrap) begin
                sh_tag_q   <= chan_q[15];
                sh_ch_lo_q <= chan_q[14:8];
                sh_ch_hi_q <= chan_q[6:0];
                sh_size_q  <= size_q;
                sh_inc_q   <= patt_q[15];
                sh_seed_q  <= patt_q[7:0];
            end
        end
    end

endmodule

// File: tb/tb_odu_gen_data.sv
// Directed bench for odu_gen_data: register access, start latency, sequencing, frame wrap,
// shadowing, stop, inverted channel range, constant pattern and mid-run reset.
module tb_odu_gen_data;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         cfg_n_cs = 1'b1;
    logic         cfg_n_we = 1'b1;
    logic         cfg_n_oe = 1'b1;
    logic [3:0]   cfg_addr = '0;
    logic [15:0]  cfg_din = '0;
    logic [15:0]  cfg_dout;
    logic [6:0]   chid_out;
    logic [386:0] data_out;

    int checks = 0;
    int errors = 0;

    logic       v, fs, rs;
    logic [7:0] b0, b1, b47;
    assign v   = data_out[386];
    assign fs  = data_out[385];
    assign rs  = data_out[384];
    assign b0  = data_out[7:0];
    assign b1  = data_out[15:8];
    assign b47 = data_out[383:376];

    odu_gen_data dut (
        .clk(clk), .rst(rst), .cfg_n_cs(cfg_n_cs), .cfg_n_we(cfg_n_we), .cfg_n_oe(cfg_n_oe),
        .cfg_addr(cfg_addr), .cfg_din(cfg_din), .cfg_dout(cfg_dout),
        .chid_out(chid_out), .data_out(data_out)
    );

    always #5 clk = ~clk;

    task automatic wr(input logic [3:0] a, input logic [15:0] d);
        @(negedge clk);
        cfg_addr = a; cfg_din = d; cfg_n_cs = 1'b0; cfg_n_we = 1'b0;
        @(posedge clk);
        #1;
        cfg_n_cs = 1'b1; cfg_n_we = 1'b1;
    endtask

    task automatic rd(input logic [3:0] a, output logic [15:0] d);
        cfg_addr = a; cfg_n_cs = 1'b0; cfg_n_oe = 1'b0;
        #1;
        d = cfg_dout;
        cfg_n_cs = 1'b1; cfg_n_oe = 1'b1;
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [15:0] d;
        #12;
        checks++; if (data_out !== 387'd0) begin errors++; $display("FAIL reset_data got %h want 0", data_out); end
        checks++; if (chid_out !== 7'd0) begin errors++; $display("FAIL reset_chid got %h want 0", chid_out); end
        checks++; if (cfg_dout !== 16'h0000) begin errors++; $display("FAIL reset_dout got %h want 0000", cfg_dout); end
        @(negedge clk);
        rst = 1'b1;
        step();
        rd(4'd0, d);
        checks++; if (d !== 16'h0D01) begin errors++; $display("FAIL id_read got %h want 0D01", d); end
    endtask

    task automatic test_regs();
        logic [15:0] d;
        wr(4'd1, 16'h8183);
        wr(4'd3, 16'h0707);
        wr(4'd6, 16'h8082);
        wr(4'd0, 16'h1234);
        rd(4'd1, d);
        checks++; if (d !== 16'h8183) begin errors++; $display("FAIL rd_chan got %h want 8183", d); end
        rd(4'd3, d);
        checks++; if (d !== 16'h0707) begin errors++; $display("FAIL rd_size got %h want 0707", d); end
        rd(4'd6, d);
        checks++; if (d !== 16'h8082) begin errors++; $display("FAIL rd_patt got %h want 8082", d); end
        rd(4'd5, d);
        checks++; if (d !== 16'h0000) begin errors++; $display("FAIL rd_unmapped got %h want 0000", d); end
        rd(4'd0, d);
        checks++; if (d !== 16'h0D01) begin errors++; $display("FAIL id_readonly got %h want 0D01", d); end
    endtask

    task automatic test_start();
        wr(4'd11, 16'h0001);
        step();
        checks++; if (v !== 1'b0) begin errors++; $display("FAIL arm_cycle valid got %b want 0", v); end
        step();
        checks++; if ({v, fs, rs} !== 3'b111 || chid_out !== 7'd1)
            begin errors++; $display("FAIL word1_flags got v%b fs%b rs%b ch%0d want 111 ch1", v, fs, rs, chid_out); end
        checks++; if (b0 !== 8'h82 || b1 !== 8'h83 || b47 !== 8'h01)
            begin errors++; $display("FAIL word1_bytes got %h %h %h want 82 83 01", b0, b1, b47); end
        step();
        checks++; if (chid_out !== 7'd2 || fs !== 1'b1) begin errors++; $display("FAIL word2 got ch%0d fs%b want ch2 fs1", chid_out, fs); end
        step();
        checks++; if (chid_out !== 7'd3 || fs !== 1'b1) begin errors++; $display("FAIL word3 got ch%0d fs%b want ch3 fs1", chid_out, fs); end
    endtask

    task automatic test_sequence();
        step();
        checks++; if (chid_out !== 7'd1 || fs !== 1'b0 || rs !== 1'b0 || b0 !== 8'h83)
            begin errors++; $display("FAIL word4 got ch%0d fs%b rs%b b0 %h want ch1 0 0 83", chid_out, fs, rs, b0); end
        repeat (21) step();
        checks++; if (chid_out !== 7'd1 || fs !== 1'b0 || rs !== 1'b1 || b0 !== 8'h8A)
            begin errors++; $display("FAIL word25 got ch%0d fs%b rs%b b0 %h want ch1 0 1 8A", chid_out, fs, rs, b0); end
    endtask

    task automatic test_frame_wrap();
        logic [15:0] d;
        logic saw3, tag_ok, found;
        repeat (168) step();
        checks++; if (chid_out !== 7'd1 || fs !== 1'b1 || b0 !== 8'h82)
            begin errors++; $display("FAIL word193 got ch%0d fs%b b0 %h want ch1 1 82", chid_out, fs, b0); end
        rd(4'd12, d);
        checks++; if (d !== 16'h0001) begin errors++; $display("FAIL stat got %h want 0001", d); end
        wr(4'd1, 16'h0102);
        saw3 = 1'b0; tag_ok = 1'b1; found = 1'b0;
        for (int i = 0; i < 250 && !found; i++) begin
            step();
            if (fs && chid_out == 7'd1) found = 1'b1;
            else begin
                if (chid_out == 7'd3) saw3 = 1'b1;
                if (b47 !== {1'b0, chid_out}) tag_ok = 1'b0;
            end
        end
        checks++; if (!saw3 || !tag_ok) begin errors++; $display("FAIL shadow_hold got saw3=%b tag_ok=%b want 1 1", saw3, tag_ok); end
        checks++; if (!found) begin errors++; $display("FAIL next_frame got found=%b want 1", found); end
        checks++; if (b47 !== 8'hB1 || b0 !== 8'h82) begin errors++; $display("FAIL newcfg_bytes got b47 %h b0 %h want B1 82", b47, b0); end
        step();
        checks++; if (chid_out !== 7'd2 || fs !== 1'b1) begin errors++; $display("FAIL newcfg_ch2 got ch%0d fs%b want ch2 fs1", chid_out, fs); end
        step();
        checks++; if (chid_out !== 7'd1 || fs !== 1'b0 || b0 !== 8'h83)
            begin errors++; $display("FAIL newcfg_wrap got ch%0d fs%b b0 %h want ch1 0 83", chid_out, fs, b0); end
    endtask

    task automatic test_stop_edge();
        int bad;
        wr(4'd11, 16'h0000);
        step();
        step();
        checks++; if (data_out !== 387'd0 || chid_out !== 7'd0)
            begin errors++; $display("FAIL stop got v%b ch%0d want all zero", v, chid_out); end
        wr(4'd1, 16'h8502);
        wr(4'd11, 16'h0001);
        step();
        step();
        checks++; if (chid_out !== 7'd5 || fs !== 1'b1 || rs !== 1'b1 || b47 !== 8'h05 || b0 !== 8'h82)
            begin errors++; $display("FAIL inv_range_first got ch%0d fs%b rs%b b47 %h b0 %h want 5 1 1 05 82", chid_out, fs, rs, b47, b0); end
        step();
        checks++; if (chid_out !== 7'd5 || rs !== 1'b0 || b0 !== 8'h83)
            begin errors++; $display("FAIL inv_range_second got ch%0d rs%b b0 %h want 5 0 83", chid_out, rs, b0); end
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (chid_out !== 7'd5 || v !== 1'b1) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL inv_range_run got %0d bad words want 0", bad); end
        wr(4'd11, 16'h0000);
        wr(4'd1, 16'h0502);
        wr(4'd6, 16'h00AA);
        wr(4'd11, 16'h0001);
        step();
        step();
        checks++; if (data_out[383:0] !== {48{8'hAA}} || v !== 1'b1 || chid_out !== 7'd5)
            begin errors++; $display("FAIL const_patt got v%b ch%0d b0 %h b47 %h want 1 5 AA AA", v, chid_out, b0, b47); end
        step();
        step();
        checks++; if (data_out[383:0] !== {48{8'hAA}} || rs !== 1'b0)
            begin errors++; $display("FAIL const_patt_later got b0 %h b47 %h rs%b want AA AA 0", b0, b47, rs); end
    endtask

    task automatic test_reset_midrun();
        logic [15:0] d;
        #1;
        rst = 1'b0;
        #1;
        checks++; if (data_out !== 387'd0 || chid_out !== 7'd0)
            begin errors++; $display("FAIL midrun_reset got v%b ch%0d want all zero", v, chid_out); end
        rd(4'd11, d);
        checks++; if (d !== 16'h0000) begin errors++; $display("FAIL midrun_ctrl got %h want 0000", d); end
        rst = 1'b1;
        step();
        step();
        checks++; if (v !== 1'b0) begin errors++; $display("FAIL after_reset valid got %b want 0", v); end
    endtask

    initial begin
        test_reset();
        test_regs();
        test_start();
        test_sequence();
        test_frame_wrap();
        test_stop_edge();
        test_reset_midrun();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
